// File: rtl/snn_aer_pkg.sv
// ============================================================================
//  Module      : snn_aer_pkg
//  Description : Shared AER event definitions for the spiking-neuron fabric.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package snn_aer_pkg;

  // Default event layout: {sign, index}, sign sits just above the index field
  localparam int AER_IDX_W_DFLT = 3;

  localparam logic SIGN_POS = 1'b1;
  localparam logic SIGN_NEG = 1'b0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } aer_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin find-first-set starting at i_ptr.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_win,
  output logic             o_any
);

  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    return (s >= N) ? (s - N) : s;
  endfunction

  // Walk offsets from farthest to nearest so the nearest request wins last
  always_comb begin
    o_any = 1'b0;
    o_win = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[wrap_idx(int'(i_ptr), k)]) begin
        o_any = 1'b1;
        o_win = IDX_W'(wrap_idx(int'(i_ptr), k));
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/spike_aer_arbiter.sv
// ============================================================================
//  Module      : spike_aer_arbiter
//  Description : Round-robin serializer of neuron spikes into an AER stream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spike_aer_arbiter
  import snn_aer_pkg::*;
#(
  parameter int N_NEURONS = 8,
  parameter int IDX_W     = AER_IDX_W_DFLT,
  parameter int DROP_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_NEURONS-1:0] pos_spk,
  input  logic [N_NEURONS-1:0] neg_spk,
  output logic                 aer_valid,
  input  logic                 aer_ready,
  output logic [IDX_W-1:0]     aer_addr,
  output logic                 aer_sign,
  output logic [N_NEURONS-1:0] pending,
  output logic                 drop_pulse,
  output logic [DROP_W-1:0]    drop_cnt
);

  localparam int CNT_W = $clog2(2 * N_NEURONS + 1);
  localparam int SUM_W = DROP_W + CNT_W;
  localparam logic [DROP_W-1:0] C_DROP_MAX = '1;

  aer_state_t             r_state;
  logic [IDX_W-1:0]       r_addr;
  logic                   r_sign;
  logic [N_NEURONS-1:0]   r_pending;
  logic [N_NEURONS-1:0]   r_pend_sign;
  logic                   r_drop_pulse;
  logic [DROP_W-1:0]      r_drop_cnt;
  logic [IDX_W-1:0]       r_rr_ptr;

  logic                   w_any;
  logic [IDX_W-1:0]       w_win;
  logic                   w_load;
  logic [N_NEURONS-1:0]   w_load_vec;
  logic [N_NEURONS-1:0]   w_cap;
  logic [N_NEURONS-1:0]   w_cap_sign;
  logic [CNT_W-1:0]       w_drops;
  logic [SUM_W-1:0]       w_sum;
  logic [DROP_W-1:0]      w_drop_cnt_nxt;

  rr_pick #(
    .N     (N_NEURONS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req (r_pending),
    .i_ptr (r_rr_ptr),
    .o_win (w_win),
    .o_any (w_any)
  );

  // A slot being handed to the output register this edge is free for capture
  always_comb begin
    w_load     = w_any && ((r_state == ST_IDLE) || aer_ready);
    w_load_vec = '0;
    if (w_load) w_load_vec[w_win] = 1'b1;
    w_cap      = '0;
    w_cap_sign = '0;
    w_drops    = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (!r_pending[i] || w_load_vec[i]) begin
        w_cap[i] = pos_spk[i] | neg_spk[i];
        w_drops  = w_drops + CNT_W'(pos_spk[i] & neg_spk[i]);
      end else begin
        w_drops  = w_drops + CNT_W'(pos_spk[i]) + CNT_W'(neg_spk[i]);
      end
      w_cap_sign[i] = pos_spk[i] ? SIGN_POS : SIGN_NEG;
    end
    w_sum          = SUM_W'(r_drop_cnt) + SUM_W'(w_drops);
    w_drop_cnt_nxt = (w_sum > SUM_W'(C_DROP_MAX)) ? C_DROP_MAX : w_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_sign       <= 1'b0;
      r_pending    <= '0;
      r_pend_sign  <= '0;
      r_drop_pulse <= 1'b0;
      r_drop_cnt   <= '0;
      r_rr_ptr     <= '0;
    end else begin
      r_pending    <= (r_pending & ~w_load_vec) | w_cap;
      r_pend_sign  <= (r_pend_sign & ~w_cap) | (w_cap_sign & w_cap);
      r_drop_pulse <= |w_drops;
      r_drop_cnt   <= w_drop_cnt_nxt;
      if (w_load) begin
        r_state  <= ST_SEND;
        r_addr   <= w_win;
        r_sign   <= r_pend_sign[w_win];
        r_rr_ptr <= (w_win == IDX_W'(N_NEURONS - 1)) ? '0 : w_win + 1'b1;
      end else if ((r_state == ST_SEND) && aer_ready) begin
        r_state <= ST_IDLE;
      end
    end
  end

  assign aer_valid  = (r_state == ST_SEND);
  assign aer_addr   = r_addr;
  assign aer_sign   = r_sign;
  assign pending    = r_pending;
  assign drop_pulse = r_drop_pulse;
  assign drop_cnt   = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_spike_aer_arbiter.sv
// ============================================================================
//  Module      : tb_spike_aer_arbiter
//  Description : Self-checking bench for spike_aer_arbiter (table + sequences).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spike_aer_arbiter;

  localparam int N  = 8;
  localparam int IW = 3;
  localparam int DW = 4;

  typedef struct {
    logic [2:0] addr;
    logic       sign;
  } ev_t;

  typedef struct {
    logic [N-1:0] pos;
    logic [N-1:0] neg;
    int           drops;
  } vec_t;

  logic          clk;
  logic          rst;
  logic [N-1:0]  pos_spk;
  logic [N-1:0]  neg_spk;
  logic          aer_valid;
  logic          aer_ready;
  logic [IW-1:0] aer_addr;
  logic          aer_sign;
  logic [N-1:0]  pending;
  logic          drop_pulse;
  logic [DW-1:0] drop_cnt;

  int  total = 0;
  int  bad   = 0;
  ev_t sb[$];
  ev_t mon_e;
  vec_t vecs[6];

  spike_aer_arbiter #(
    .N_NEURONS (N),
    .IDX_W     (IW),
    .DROP_W    (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pos_spk    (pos_spk),
    .neg_spk    (neg_spk),
    .aer_valid  (aer_valid),
    .aer_ready  (aer_ready),
    .aer_addr   (aer_addr),
    .aer_sign   (aer_sign),
    .pending    (pending),
    .drop_pulse (drop_pulse),
    .drop_cnt   (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Handshake monitor; ready only changes just after posedge, so negedge is safe
  always @(negedge clk) begin
    if (!rst && aer_valid && aer_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected act=addr%0d/sign%0d exp=none", aer_addr, aer_sign);
      end else begin
        mon_e = sb.pop_front();
        if (aer_addr !== mon_e.addr || aer_sign !== mon_e.sign) begin
          bad++;
          $display("FAIL sb_event act=addr%0d/sign%0d exp=addr%0d/sign%0d",
                   aer_addr, aer_sign, mon_e.addr, mon_e.sign);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic push(input int a, input logic s);
    ev_t e;
    e.addr = 3'(a);
    e.sign = s;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    pos_spk   = '0;
    neg_spk   = '0;
    aer_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic drain(input string name);
    aer_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (sb.size() == 0 && !aer_valid) break;
      tick();
    end
    chk({name, "_left"}, sb.size(), 0);
    chk({name, "_idle"}, int'(aer_valid), 0);
  endtask

  initial begin
    vecs[0] = '{pos: 8'h20, neg: 8'h00, drops: 0};
    vecs[1] = '{pos: 8'h00, neg: 8'hFF, drops: 0};
    vecs[2] = '{pos: 8'h40, neg: 8'h40, drops: 1};
    vecs[3] = '{pos: 8'hA5, neg: 8'h5A, drops: 0};
    vecs[4] = '{pos: 8'h0F, neg: 8'hFF, drops: 4};
    vecs[5] = '{pos: 8'h81, neg: 8'h00, drops: 0};

    // Reset state
    do_reset();
    chk("rst_valid", int'(aer_valid), 0);
    chk("rst_addr", int'(aer_addr), 0);
    chk("rst_sign", int'(aer_sign), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_dpulse", int'(drop_pulse), 0);
    chk("rst_dcnt", int'(drop_cnt), 0);

    // Table: one-edge pulse after reset, ready high, ascending order from 0
    for (int v = 0; v < 6; v++) begin
      do_reset();
      aer_ready = 1'b1;
      pos_spk   = vecs[v].pos;
      neg_spk   = vecs[v].neg;
      for (int i = 0; i < N; i++)
        if (vecs[v].pos[i] || vecs[v].neg[i]) push(i, vecs[v].pos[i]);
      tick();
      pos_spk = '0;
      neg_spk = '0;
      drain("vec_drain");
      chk("vec_dcnt", int'(drop_cnt), vecs[v].drops);
    end

    // Latency: single spike on neuron 5
    do_reset();
    aer_ready = 1'b1;
    pos_spk   = 8'h20;
    push(5, 1'b1);
    tick();
    pos_spk = '0;
    chk("lat_k_valid", int'(aer_valid), 0);
    chk("lat_k_pend", int'(pending), 32'h20);
    tick();
    chk("lat_k1_valid", int'(aer_valid), 1);
    chk("lat_k1_addr", int'(aer_addr), 5);
    chk("lat_k1_sign", int'(aer_sign), 1);
    chk("lat_k1_pend", int'(pending), 0);
    tick();
    chk("lat_k2_valid", int'(aer_valid), 0);

    // Reset mid-SEND discards in-flight event, drops and pointer
    do_reset();
    pos_spk = 8'h12;
    neg_spk = 8'h10;
    tick();
    pos_spk = '0;
    neg_spk = '0;
    tick();
    chk("mid_pre_valid", int'(aer_valid), 1);
    chk("mid_pre_dcnt", int'(drop_cnt), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("mid_valid", int'(aer_valid), 0);
    chk("mid_pending", int'(pending), 0);
    chk("mid_dcnt", int'(drop_cnt), 0);
    chk("mid_dpulse", int'(drop_pulse), 0);
    aer_ready = 1'b1;
    neg_spk   = 8'hFF;
    for (int i = 0; i < N; i++) push(i, 1'b0);
    tick();
    neg_spk = '0;
    drain("mid_drain");

    // Fairness: full burst without gaps, then burst rotated after neuron 3
    do_reset();
    aer_ready = 1'b1;
    neg_spk   = 8'hFF;
    for (int i = 0; i < N; i++) push(i, 1'b0);
    tick();
    neg_spk = '0;
    tick();
    for (int c = 0; c < N; c++) begin
      chk("burst_gap", int'(aer_valid), 1);
      tick();
    end
    chk("burst_end", int'(aer_valid), 0);
    pos_spk = 8'h08;
    push(3, 1'b1);
    tick();
    pos_spk = '0;
    drain("n3_drain");
    neg_spk = 8'hFF;
    for (int i = 0; i < N; i++) push((i + 4) % N, 1'b0);
    tick();
    neg_spk = '0;
    drain("rot_drain");

    // Backpressure on neuron 2
    do_reset();
    pos_spk = 8'h04;
    push(2, 1'b1);
    tick();
    pos_spk = '0;
    tick();
    chk("bp_valid", int'(aer_valid), 1);
    chk("bp_addr", int'(aer_addr), 2);
    for (int c = 0; c < 20; c++) begin
      if (c == 5 || c == 10) pos_spk = 8'h04;
      tick();
      pos_spk = '0;
      chk("bp_hold_valid", int'(aer_valid), 1);
      chk("bp_hold_addr", int'(aer_addr), 2);
      chk("bp_hold_sign", int'(aer_sign), 1);
      if (c == 5) begin
        chk("bp_refill_pend", int'(pending[2]), 1);
        chk("bp_refill_dcnt", int'(drop_cnt), 0);
        push(2, 1'b1);
      end
      if (c == 10) begin
        chk("bp_drop_pulse", int'(drop_pulse), 1);
        chk("bp_drop_cnt", int'(drop_cnt), 1);
      end
      if (c == 11) chk("bp_drop_pulse_off", int'(drop_pulse), 0);
    end
    drain("bp_drain");

    // Saturation of the 4-bit drop counter over 20 drops
    do_reset();
    pos_spk = 8'hFF;
    tick();
    pos_spk = 8'h0F;
    tick();
    chk("sat_cnt3", int'(drop_cnt), 3);
    chk("sat_pulse", int'(drop_pulse), 1);
    chk("sat_addr0", int'(aer_addr), 0);
    pos_spk = 8'hFF;
    neg_spk = 8'hFF;
    tick();
    chk("sat_cnt15", int'(drop_cnt), 15);
    pos_spk = 8'h01;
    neg_spk = '0;
    tick();
    chk("sat_hold", int'(drop_cnt), 15);
    chk("sat_pulse2", int'(drop_pulse), 1);
    pos_spk = '0;
    tick();
    chk("sat_quiet_cnt", int'(drop_cnt), 15);
    chk("sat_quiet_pulse", int'(drop_pulse), 0);
    push(0, 1'b1);
    for (int i = 1; i < N; i++) push(i, 1'b1);
    push(0, 1'b1);
    drain("sat_drain");
    chk("sat_final", int'(drop_cnt), 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
